mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_if.sv | 18 +
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Core-side memory-mapped bus for mmio_uart_tx: store strobe, address, data, and read-back mux controls.
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] RdData;
    logic        sel;

    modport master (
        output MemWrite, ALUResult, WriteData,
        input  RdData, sel
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData,
        output RdData, sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, transmit FIFO, 8N1 serializer.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            tx
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned BCW  = $clog2(CLKS_PER_BIT);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;
    logic              overflow;
    logic [BCW-1:0]    bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_q, shift_d;
    logic              tx_d;
    logic              pop, reload, shift_en;
    logic              fifo_empty, fifo_full, bit_done, busy;
    logic              wr_txdata, wr_status, push_ok;
    logic [7:0]        fifo_head;
    logic [31:0]       status;
`ifdef UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Low data bytes are the only part of a store this block consumes.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.WriteData[31:8]};

    // Address decode and combinational read-back.
    assign bus.sel    = (bus.ALUResult[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata  = bus.MemWrite && bus.sel && (bus.ALUResult[2:0] == 3'b000);
    assign wr_status  = bus.MemWrite && bus.sel && (bus.ALUResult[2:0] == 3'b100);
    assign bus.RdData = (bus.sel && (bus.ALUResult[2:0] == 3'b100)) ? status : 32'h0;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNTW'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr];
    assign bit_done   = (bit_cnt == '0);
    assign busy       = (state_q != IDLE);
    assign push_ok    = wr_txdata && (!fifo_full || pop);
    assign status     = {21'h0, 7'(count), overflow, busy, fifo_empty, fifo_full};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic plus the datapath controls it issues.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        reload   = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    reload  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    reload  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    reload   = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    reload  = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        reload  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line value is computed from the upcoming state so tx registers in step with the FSM.
    always_comb begin
        shift_d = shift_q;
        if (pop)           shift_d = fifo_head;
        else if (shift_en) shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_PARITY_EN
        parity_d = pop ? ^fifo_head : parity_q;
`endif
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
    end

    // FIFO bookkeeping, bit timing, shifter and line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(push_ok) - CNTW'(pop);

            if (wr_txdata && !push_ok) overflow <= 1'b1;
            else if (wr_status)        overflow <= 1'b0;

            if (reload)         bit_cnt <= BCW'(CLKS_PER_BIT - 1);
            else if (!bit_done) bit_cnt <= bit_cnt - 1'b1;

            if (pop)           bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;

            shift_q <= shift_d;
            tx      <= tx_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x1000).
module tb_mmio_uart_tx;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int unsigned FL = 11 * CPB;
`else
    localparam int unsigned FL = 10 * CPB;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tx;
    int   n_cmp = 0;
    int   n_bad = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR   (32'h0000_1000),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level k cycles after the frame's first START cycle.
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.MemWrite = 1'b0;
        bus.ALUResult = 32'h1004;
        bus.WriteData = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h want %h", bus.RdData, 32'h2); end
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (bus.sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel_status: got %b want 1", bus.sel); end
        bus.ALUResult = 32'h1008;
        #1;
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL sel_1008: got %b want 0", bus.sel); end
        n_cmp++; if (bus.RdData !== 32'h0) begin n_bad++; $display("FAIL rd_1008: got %h want 0", bus.RdData); end
        bus.ALUResult = 32'h0FFC;
        #1;
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL sel_0ffc: got %b want 0", bus.sel); end
        bus.ALUResult = 32'h1000;
        #1;
        n_cmp++; if (bus.sel !== 1'b1) begin n_bad++; $display("FAIL sel_txdata: got %b want 1", bus.sel); end
        n_cmp++; if (bus.RdData !== 32'h0) begin n_bad++; $display("FAIL rd_txdata: got %h want 0", bus.RdData); end
        bus.ALUResult = 32'h1004;
    endtask

    task automatic test_ignored_store();
        logic [31:0] addrs [3];
        addrs[0] = 32'h1002;
        addrs[1] = 32'h1006;
        addrs[2] = 32'h1008;
        for (int i = 0; i < 3; i++) begin
            bus.MemWrite  = 1'b1;
            bus.ALUResult = addrs[i];
            bus.WriteData = 32'h0000_00FF;
            tick();
        end
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h1004;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL ignored_status: got %h want %h", bus.RdData, 32'h2); end
            n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL ignored_tx: got %b want 1", tx); end
        end
    endtask

    task automatic test_frame(input logic [7:0] d);
        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h1000;
        bus.WriteData = {24'hDEADBE, d};
        tick();
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h1004;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL frame_store_edge_tx: got %b want 1", tx); end
        n_cmp++; if (bus.RdData !== 32'h10) begin n_bad++; $display("FAIL frame_queued_status: got %h want %h", bus.RdData, 32'h10); end
        for (int k = 0; k < int'(FL); k++) begin
            tick();
            n_cmp++; if (tx !== exp_tx(d, k)) begin n_bad++; $display("FAIL frame_%h_tx k=%0d: got %b want %b", d, k, tx, exp_tx(d, k)); end
            n_cmp++; if (bus.RdData[2] !== 1'b1) begin n_bad++; $display("FAIL frame_%h_busy k=%0d: got %b want 1", d, k, bus.RdData[2]); end
        end
        tick();
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL frame_%h_end_tx: got %b want 1", d, tx); end
        n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL frame_%h_end_status: got %h want %h", d, bus.RdData, 32'h2); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            bus.MemWrite  = 1'b1;
            bus.ALUResult = 32'h1000;
            bus.WriteData = 32'(8'hA1 + i);
            tick();
            if (i > 0) begin
                n_cmp++; if (tx !== exp_tx(8'hA1, i - 1)) begin n_bad++; $display("FAIL b2b_fill_tx i=%0d: got %b want %b", i, tx, exp_tx(8'hA1, i - 1)); end
            end
        end
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h1004;
        #1;
        n_cmp++; if (bus.RdData !== 32'h45) begin n_bad++; $display("FAIL b2b_full_status: got %h want %h", bus.RdData, 32'h45); end
        for (int k = 4; k < 5 * int'(FL); k++) begin
            tick();
            d = 8'(8'hA1 + k / int'(FL));
            n_cmp++; if (tx !== exp_tx(d, k % int'(FL))) begin n_bad++; $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx, exp_tx(d, k % int'(FL))); end
        end
        tick();
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL b2b_end_tx: got %b want 1", tx); end
        n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL b2b_end_status: got %h want %h", bus.RdData, 32'h2); end
    endtask

    task automatic test_overflow();
        logic drained;
        for (int i = 0; i < 6; i++) begin
            bus.MemWrite  = 1'b1;
            bus.ALUResult = 32'h1000;
            bus.WriteData = 32'(8'hB0 + i);
            tick();
        end
        bus.MemWrite = 1'b0;
        n_cmp++; if (bus.RdData !== 32'h0) begin n_bad++; $display("FAIL ovf_txdata_read: got %h want 0", bus.RdData); end
        bus.ALUResult = 32'h1004;
        #1;
        n_cmp++; if (bus.RdData !== 32'h4D) begin n_bad++; $display("FAIL ovf_set_status: got %h want %h", bus.RdData, 32'h4D); end
        bus.MemWrite  = 1'b1;
        bus.WriteData = 32'h0;
        tick();
        bus.MemWrite = 1'b0;
        n_cmp++; if (bus.RdData !== 32'h45) begin n_bad++; $display("FAIL ovf_clear_status: got %h want %h", bus.RdData, 32'h45); end
        drained = 1'b0;
        for (int i = 0; i < 6 * int'(FL) && !drained; i++) begin
            tick();
            if (bus.RdData === 32'h2) drained = 1'b1;
        end
        n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL ovf_drain: got status %h want %h", bus.RdData, 32'h2); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) begin
            bus.MemWrite  = 1'b1;
            bus.ALUResult = 32'h1000;
            bus.WriteData = 32'(8'hC1 + i);
            tick();
        end
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h1004;
        for (int k = 2; k <= 14; k++) tick();
        n_cmp++; if (tx !== exp_tx(8'hC1, 14)) begin n_bad++; $display("FAIL midrst_pre_tx: got %b want %b", tx, exp_tx(8'hC1, 14)); end
        n_cmp++; if (bus.RdData !== 32'h24) begin n_bad++; $display("FAIL midrst_pre_status: got %h want %h", bus.RdData, 32'h24); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx: got %b want 1", tx); end
        n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL midrst_status: got %h want %h", bus.RdData, 32'h2); end
        for (int k = 0; k < 3 * int'(FL); k++) begin
            tick();
            n_cmp++; if (tx !== 1'b1 || bus.RdData !== 32'h2) begin n_bad++; $display("FAIL midrst_quiet k=%0d: got tx=%b status=%h want tx=1 status=%h", k, tx, bus.RdData, 32'h2); end
        end
    endtask

    task automatic test_reset_store();
        reset         = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.ALUResult = 32'h1000;
        bus.WriteData = 32'h3C;
        tick();
        reset         = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h1004;
        #1;
        n_cmp++; if (bus.RdData !== 32'h2) begin n_bad++; $display("FAIL rststore_status: got %h want %h", bus.RdData, 32'h2); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (tx !== 1'b1 || bus.RdData !== 32'h2) begin n_bad++; $display("FAIL rststore_quiet k=%0d: got tx=%b status=%h want tx=1 status=%h", k, tx, bus.RdData, 32'h2); end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h0;
        bus.WriteData = 32'h0;
        test_reset();
        test_ignored_store();
        test_frame(8'h55);
        test_frame(8'h07);
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_reset_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
